// File: rtl/regfile_param_if.sv
// Register-file port bundle: two write ports, two read ports and the Ready flag.
// The master side (core/bench) drives writes and read indexes; the slave side
// (the register file) returns read data and Ready.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              Ready;
    logic              W_en0;
    logic              W_en1;
    logic [ADDR_W-1:0] Rd0;
    logic [ADDR_W-1:0] Rd1;
    logic [DATA_W-1:0] Wr_data0;
    logic [DATA_W-1:0] Wr_data1;
    logic [ADDR_W-1:0] Rs1;
    logic [ADDR_W-1:0] Rs2;
    logic [DATA_W-1:0] Rd_data1;
    logic [DATA_W-1:0] Rd_data2;

    modport master (
        output W_en0, W_en1, Rd0, Rd1, Wr_data0, Wr_data1, Rs1, Rs2,
        input  Ready, Rd_data1, Rd_data2
    );

    modport slave (
        input  W_en0, W_en1, Rd0, Rd1, Wr_data0, Wr_data1, Rs1, Rs2,
        output Ready, Rd_data1, Rd_data2
    );
endinterface

// File: rtl/regfile_param.sv
// Parameterised 2-write / 2-read register file.
// After reset an INIT sweep zeroes every entry one per clock; only then does
// the block go live (Ready=1). Reads are combinational with optional
// same-cycle write forwarding and an optional hardwired-zero register 0.
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_param_if.slave  bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic              ready_q;
    logic [DATA_W-1:0] regs_q [NREG];

    // Per-port write request, index and data gathered into arrays so the
    // two ports can be handled uniformly below.
    logic [1:0]        wr_req;
    logic [1:0]        wr_en;
    logic [ADDR_W-1:0] wr_idx [2];
    logic [DATA_W-1:0] wr_dat [2];
    logic [ADDR_W-1:0] rd_idx [2];

    assign wr_req    = {bus.W_en1, bus.W_en0};
    assign wr_idx[0] = bus.Rd0;
    assign wr_idx[1] = bus.Rd1;
    assign wr_dat[0] = bus.Wr_data0;
    assign wr_dat[1] = bus.Wr_data1;
    assign rd_idx[0] = bus.Rs1;
    assign rd_idx[1] = bus.Rs2;

    genvar gi;

    // A write is effective only while live and when it does not target a
    // hardwired-zero register 0.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr
            assign wr_en[gi] = wr_req[gi] && (state_q == ST_RUN) &&
                               !((ZERO_R0 != 0) && (wr_idx[gi] == '0));
        end
    endgenerate

    // Control FSM: INIT sweeps clr_idx across every entry, then RUN forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else if (state_q == ST_INIT) begin
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
                clr_idx_q <= '0;
                state_q   <= ST_RUN;
                ready_q   <= 1'b1;
            end else begin
                clr_idx_q <= clr_idx_q + 1'b1;
            end
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Storage: no reset of its own; it is zeroed only by the INIT sweep.
    // Writes are held off while rst_n is low so a long reset cannot touch it.
    // Port 1 is applied last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                regs_q[clr_idx_q] <= '0;
            end else begin
                if (wr_en[0]) regs_q[wr_idx[0]] <= wr_dat[0];
                if (wr_en[1]) regs_q[wr_idx[1]] <= wr_dat[1];
            end
        end
    end

    // Read ports: stored value, optionally overridden by this cycle's write
    // (port 1 over port 0); forced to zero while not live or for zero-r0.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_val;

            always_comb begin
                rd_val = regs_q[rd_idx[gi]];
                if (BYPASS != 0) begin
                    if (wr_en[0] && (wr_idx[0] == rd_idx[gi])) rd_val = wr_dat[0];
                    if (wr_en[1] && (wr_idx[1] == rd_idx[gi])) rd_val = wr_dat[1];
                end
                if ((state_q != ST_RUN) || ((ZERO_R0 != 0) && (rd_idx[gi] == '0)))
                    rd_val = '0;
            end
        end
    endgenerate

    assign bus.Rd_data1 = g_rd[0].rd_val;
    assign bus.Rd_data2 = g_rd[1].rd_val;
    assign bus.Ready    = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param. Three 32x32 instances
// (defaults, no bypass, ordinary r0) share one stimulus stream and are
// compared against a behavioural model; a 16-bit/8-entry instance covers
// the small-parameter case.
module tb_regfile_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        w_en0, w_en1;
    logic [4:0]  rd0, rd1, rs1, rs2;
    logic [31:0] wd0, wd1;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ifc ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifd ();

    assign {ifa.W_en0, ifa.W_en1, ifa.Rd0, ifa.Rd1, ifa.Wr_data0, ifa.Wr_data1, ifa.Rs1, ifa.Rs2} =
           {w_en0, w_en1, rd0, rd1, wd0, wd1, rs1, rs2};
    assign {ifb.W_en0, ifb.W_en1, ifb.Rd0, ifb.Rd1, ifb.Wr_data0, ifb.Wr_data1, ifb.Rs1, ifb.Rs2} =
           {w_en0, w_en1, rd0, rd1, wd0, wd1, rs1, rs2};
    assign {ifc.W_en0, ifc.W_en1, ifc.Rd0, ifc.Rd1, ifc.Wr_data0, ifc.Wr_data1, ifc.Rs1, ifc.Rs2} =
           {w_en0, w_en1, rd0, rd1, wd0, wd1, rs1, rs2};

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .BYPASS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1), .BYPASS(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    // Reference contents for configs 0 (a), 1 (b), 2 (c).
    logic [31:0] mdl [3][32];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cfg_zr(int c);
        return c != 2;
    endfunction

    function automatic bit cfg_byp(int c);
        return c != 1;
    endfunction

    // What a read of index rs should return right now, from the rules:
    // r0 hardwired zero, forwarding of this cycle's write (port 1 first), else contents.
    function automatic logic [31:0] exp_read(int c, logic [4:0] rs);
        if (cfg_zr(c) && rs == 5'd0) return 32'd0;
        if (cfg_byp(c) && w_en1 && rd1 == rs) return wd1;
        if (cfg_byp(c) && w_en0 && rd0 == rs) return wd0;
        return mdl[c][rs];
    endfunction

    function automatic logic [31:0] obs_read(int c, int port);
        case (c)
            0:       return (port == 0) ? ifa.Rd_data1 : ifa.Rd_data2;
            1:       return (port == 0) ? ifb.Rd_data1 : ifb.Rd_data2;
            default: return (port == 0) ? ifc.Rd_data1 : ifc.Rd_data2;
        endcase
    endfunction

    // Apply this edge's writes in port order, so port 1 naturally overwrites.
    task automatic model_commit();
        for (int c = 0; c < 3; c++) begin
            if (w_en0 && !(cfg_zr(c) && rd0 == 5'd0)) mdl[c][rd0] = wd0;
            if (w_en1 && !(cfg_zr(c) && rd1 == 5'd0)) mdl[c][rd1] = wd1;
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 32; r++) mdl[c][r] = 32'd0;
    endtask

    task automatic idle();
        w_en0 = 1'b0;
        w_en1 = 1'b0;
    endtask

    // One RUN transaction: compare both read ports of all three configs, then clock it.
    task automatic step();
        #1;
        txn++;
        $display("txn %0d: we0=%b rd0=%0d wd0=%h we1=%b rd1=%0d wd1=%h rs1=%0d rs2=%0d",
                 txn, w_en0, rd0, wd0, w_en1, rd1, wd1, rs1, rs2);
        for (int c = 0; c < 3; c++) begin
            check_val($sformatf("rd1_cfg%0d_rs%0d", c, rs1), obs_read(c, 0), exp_read(c, rs1));
            check_val($sformatf("rd2_cfg%0d_rs%0d", c, rs2), obs_read(c, 1), exp_read(c, rs2));
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // INIT sweep after rst_n has just been released on a falling edge:
    // Ready low through edge 31, high from edge 32 (edge 8 for the small one).
    // Port 0 keeps writing x5 throughout to show INIT ignores it.
    task automatic sweep(input string tag);
        w_en0 = 1'b1; rd0 = 5'd5; rs1 = 5'd5; w_en1 = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            wd0 = 32'h5A5A_0000 + 32'(i);
            @(posedge clk);
            #1;
            check_val($sformatf("%s_ready_a_e%0d", tag, i), 32'(ifa.Ready), 32'(i == 32));
            check_val($sformatf("%s_ready_d_e%0d", tag, i), 32'(ifd.Ready), 32'(i >= 8));
            if (i < 32) check_val($sformatf("%s_init_rd_e%0d", tag, i), ifa.Rd_data1, 32'd0);
        end
        idle();
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        rd0 = '0; rd1 = '0; wd0 = '0; wd1 = '0; rs1 = '0; rs2 = '0;
        ifd.W_en0 = 1'b0; ifd.W_en1 = 1'b0; ifd.Rd0 = '0; ifd.Rd1 = '0;
        ifd.Wr_data0 = '0; ifd.Wr_data1 = '0; ifd.Rs1 = '0; ifd.Rs2 = '0;
        model_clear();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready_a", 32'(ifa.Ready), 32'd0);
        check_val("rst_rd1_a", ifa.Rd_data1, 32'd0);
        check_val("rst_ready_d", 32'(ifd.Ready), 32'd0);

        // First INIT sweep, then read every register on both ports.
        @(negedge clk);
        rst_n = 1'b1;
        sweep("init1");
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            rs2 = 5'(31 - r);
            step();
        end

        // Same-cycle forwarding vs. next-cycle visibility.
        w_en0 = 1'b1; rd0 = 5'd5; wd0 = 32'hDEAD_BEEF; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        check_val("byp_a_x5", ifa.Rd_data1, 32'hDEAD_BEEF);
        check_val("nobyp_b_x5", ifb.Rd_data1, 32'd0);
        step();
        idle();
        #1;
        check_val("nobyp_b_x5_next", ifb.Rd_data1, 32'hDEAD_BEEF);
        step();

        // Collision on x7 (port 1 wins), then two independent writes.
        w_en0 = 1'b1; rd0 = 5'd7; wd0 = 32'h11;
        w_en1 = 1'b1; rd1 = 5'd7; wd1 = 32'h22;
        rs1 = 5'd7; rs2 = 5'd6;
        step();
        rd0 = 5'd8; wd0 = 32'h33; rd1 = 5'd9; wd1 = 32'h44;
        #1;
        check_val("collide_a_x7", ifa.Rd_data1, 32'h22);
        step();
        idle();
        rs1 = 5'd8; rs2 = 5'd9;
        #1;
        check_val("dual_a_x8", ifa.Rd_data1, 32'h33);
        check_val("dual_a_x9", ifa.Rd_data2, 32'h44);
        step();

        // Writes to x0 on both ports.
        w_en0 = 1'b1; rd0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        w_en1 = 1'b1; rd1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        rs1 = 5'd0; rs2 = 5'd1;
        #1;
        check_val("x0_a_same", ifa.Rd_data1, 32'd0);
        step();
        idle();
        #1;
        check_val("x0_a_later", ifa.Rd_data1, 32'd0);
        check_val("x0_c_later", ifc.Rd_data1, 32'hFFFF_FFFF);
        step();
        step();

        // Randomised traffic, reads biased toward the indexes being written.
        repeat (300) begin
            w_en0 = 1'($urandom_range(0, 1));
            w_en1 = 1'($urandom_range(0, 1));
            rd0 = 5'($urandom); rd1 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rd1 = rd0;
            wd0 = $urandom; wd1 = $urandom;
            rs1 = ($urandom_range(0, 1) == 1) ? rd0 : 5'($urandom);
            rs2 = ($urandom_range(0, 1) == 1) ? rd1 : 5'($urandom);
            step();
        end
        idle();

        // Put a value in x3, then reset mid-RUN and again mid-INIT.
        w_en0 = 1'b1; rd0 = 5'd3; wd0 = 32'hCAFE_0003; rs1 = 5'd4; rs2 = 5'd2;
        step();
        idle();
        rs1 = 5'd3;
        #1;
        check_val("x3_before_rst", ifa.Rd_data1, 32'hCAFE_0003);
        rst_n = 1'b0;
        #1;
        check_val("midrun_rst_ready", 32'(ifa.Ready), 32'd0);
        check_val("midrun_rst_rd1", ifa.Rd_data1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("init_e%0d_ready", i), 32'(ifa.Ready), 32'd0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midinit_rst_ready", 32'(ifa.Ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("init2");
        rs1 = 5'd3; rs2 = 5'd3;
        #1;
        check_val("x3_cleared_a", ifa.Rd_data1, 32'd0);
        check_val("x3_cleared_b", ifb.Rd_data1, 32'd0);
        check_val("x3_cleared_c", ifc.Rd_data2, 32'd0);
        step();

        // Small instance: 16-bit data, 8 entries.
        ifd.W_en0 = 1'b1; ifd.Rd0 = 3'd7; ifd.Wr_data0 = 16'hA5A5;
        ifd.W_en1 = 1'b1; ifd.Rd1 = 3'd0; ifd.Wr_data1 = 16'h1234;
        ifd.Rs1 = 3'd7; ifd.Rs2 = 3'd0;
        #1;
        check_val("d_x7_byp", 32'(ifd.Rd_data1), 32'h0000_A5A5);
        @(posedge clk);
        #1;
        ifd.W_en0 = 1'b0; ifd.W_en1 = 1'b0;
        #1;
        $display("txn d: wrote x7=a5a5 x0=1234, read x7=%h x0=%h", ifd.Rd_data1, ifd.Rd_data2);
        check_val("d_x7_stored", 32'(ifd.Rd_data1), 32'h0000_A5A5);
        check_val("d_x0_zero", 32'(ifd.Rd_data2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register index width; depth NREG = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_R0, default 1, register 0 hardwired to zero when 1.
REQ-004 The block SHALL have parameter BYPASS, default 1, same-cycle write-to-read forwarding when 1.
REQ-005 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port Ready  output  1  high when init clear is done and ports are live.
REQ-008 The block SHALL have ports W_en0 / W_en1  input  1  write enables, ports 0/1.
REQ-009 The block SHALL have ports Rd0 / Rd1  input  ADDR_W  write indexes, ports 0/1.
REQ-010 The block SHALL have ports Wr_data0 / Wr_data1  input  DATA_W  write data, ports 0/1.
REQ-011 The block SHALL have ports Rs1 / Rs2  input  ADDR_W  read indexes.
REQ-012 The block SHALL have ports Rd_data1 / Rd_data2  output  DATA_W  combinational read data.

Function
REQ-013 The block SHALL implement a two-state FSM, INIT and RUN, plus a clear counter clr_idx of ADDR_W bits.
REQ-014 In INIT, each rising clk edge SHALL write zero to regs[clr_idx] and increment clr_idx.
REQ-015 When clr_idx = NREG-1 in INIT, the block SHALL write that entry, wrap clr_idx to 0 and enter RUN on the same edge.
REQ-016 Ready SHALL be 1 exactly when the state is RUN, so Ready rises NREG clk edges after rst_n deasserts.
REQ-017 In INIT, W_en0/W_en1 SHALL be ignored and Rd_data1/Rd_data2 SHALL read 0.
REQ-018 In RUN, on each rising edge, port p SHALL write Wr_data<p> to regs[Rd<p>] when W_en<p>=1, unless ZERO_R0=1 and Rd<p>=0.
REQ-019 When both ports write the same index on the same edge, port 1 SHALL win.
REQ-020 When both ports write different indexes on the same edge, both writes SHALL complete.
REQ-021 Reads SHALL be combinational, with zero latency from Rs to Rd_data.
REQ-022 When ZERO_R0=1 and Rs=0, the read SHALL return 0 regardless of any write.
REQ-023 When BYPASS=1 in RUN and Rs matches an enabled, non-suppressed write index this cycle, the read SHALL return that Wr_data (port 1 over port 0); otherwise it SHALL return the stored value.
REQ-024 When BYPASS=0, reads SHALL return only the stored value, with the new value visible the cycle after the write.
REQ-025 With ZERO_R0=0, register 0 SHALL behave as an ordinary register.

Reset
REQ-026 While rst_n=0, the block SHALL hold state=INIT, clr_idx=0, Ready=0 and Rd_data1/Rd_data2=0, independent of clk.
REQ-027 Storage SHALL NOT be cleared by rst_n directly; only the INIT sweep clears it.
REQ-028 Asserting rst_n mid-INIT or mid-RUN SHALL abort immediately, and the sweep SHALL restart from index 0 after deassertion.

Verification
REQ-029 Bench: release rst_n with defaults -> Ready=0 for 32 edges, Ready=1 after the 32nd; all 32 reads return 0; W_en0 pulsed during INIT has no effect.
REQ-030 Bench: RUN, write 0xDEADBEEF to x5 via port 0 with Rs1=5 in the same cycle -> Rd_data1=0xDEADBEEF combinationally (BYPASS=1); with BYPASS=0 it reads 0 then 0xDEADBEEF next cycle.
REQ-031 Bench: port 0 writes 0x11 and port 1 writes 0x22 to x7 on one edge -> x7=0x22; a simultaneous write of 0x33 to x8 and 0x44 to x9 -> both stored.
REQ-032 Bench: write 0xFFFFFFFF to x0 on both ports with Rs1=0 -> Rd_data1=0 in the same and every later cycle; with ZERO_R0=0, x0 reads 0xFFFFFFFF next cycle.
REQ-033 Bench: pulse rst_n low at INIT count 10, with x3 holding a value from earlier RUN -> Ready stays 0 for 32 edges after release, then x3 reads 0.
REQ-034 Bench: DATA_W=16, ADDR_W=3 -> Ready after 8 edges; write 0xA5A5 to x7 and read it back correctly.
